// File: rtl/lib_pkg.sv
// Shared types for the data-memory responder: access sizes (RISC-V funct3[1:0])
// and the responder FSM states.
package lib_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_RESP
    } dmem_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store-byte merge, load extraction with sign/zero
// extension, and misalignment / illegal-size detection.
module mem_align
    import lib_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [31:0] byte_shift;
    logic [31:0] half_shift;

    always_comb begin
        store_word = old_word;
        load_data  = '0;
        misalign   = 1'b0;
        byte_shift = old_word >> {addr_lo, 3'b000};
        half_shift = old_word >> {addr_lo[1], 4'b0000};
        case (size)
            MEM_B: begin
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                load_data = {{24{~is_unsigned & byte_shift[7]}}, byte_shift[7:0]};
            end
            MEM_H: begin
                misalign = addr_lo[0];
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                load_data = {{16{~is_unsigned & half_shift[15]}}, half_shift[15:0]};
            end
            MEM_W: begin
                misalign   = |addr_lo;
                store_word = wdata;
                load_data  = old_word;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request channel, configurable wait states,
// one-cycle response pulse. Loads and stores commit on the edge entering RESP.
module dmem_responder
    import lib_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DADDR   = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [DADDR-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_err
);

    localparam int unsigned DEPTH    = 2 ** (DADDR - 2);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    dmem_state_t      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [DADDR-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             commit;
    logic             sel_we, sel_uns;
    logic [1:0]       sel_size;
    logic [DADDR-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic [WIDTH-1:0] store_word, load_data;
    logic             misalign;

    assign req_ready  = (state_q == DM_IDLE);
    assign resp_valid = (state_q == DM_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With zero latency the commit edge is the accept edge, so the live request
    // feeds the lane logic in IDLE; otherwise the latched copy does.
    always_comb begin
        if (state_q == DM_IDLE) begin
            sel_we    = req_we;
            sel_size  = req_size;
            sel_uns   = req_unsigned;
            sel_addr  = req_addr;
            sel_wdata = req_wdata;
        end else begin
            sel_we    = we_q;
            sel_size  = size_q;
            sel_uns   = uns_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
    end

    mem_align u_align (
        .size        (sel_size),
        .is_unsigned (sel_uns),
        .addr_lo     (sel_addr[1:0]),
        .old_word    (mem[sel_addr[DADDR-1:2]]),
        .wdata       (sel_wdata),
        .store_word  (store_word),
        .load_data   (load_data),
        .misalign    (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        commit  = 1'b0;
        case (state_q)
            DM_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (LATENCY == 0) begin
                        state_d = DM_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = DM_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            DM_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DM_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DM_RESP: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
        if (commit) begin
            err_d   = misalign;
            rdata_d = (sel_we || misalign) ? '0 : load_data;
        end
    end

    // The array has no reset; it only updates from the functional branch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DM_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (commit && sel_we && !misalign) begin
                mem[sel_addr[DADDR-1:2]] <= store_word;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: byte-addressed reference model,
// directed cases, randomized traffic, and a zero-latency instance.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_valid, a_ready, a_we, a_uns, a_rv, a_err;
    logic [1:0]  a_size;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;

    logic        b_valid, b_ready, b_we, b_uns, b_rv, b_err;
    logic [1:0]  b_size;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;

    dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(rst_n),
        .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we), .req_size(a_size),
        .req_unsigned(a_uns), .req_addr(a_addr), .req_wdata(a_wdata),
        .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err)
    );

    dmem_responder #(.WIDTH(32), .DADDR(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(rst_n),
        .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we), .req_size(b_size),
        .req_unsigned(b_uns), .req_addr(b_addr), .req_wdata(b_wdata),
        .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
        string       tag;
    } exp_t;
    exp_t sbq[$];

    logic [7:0] mb [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Little-endian byte memory; sub-word loads are assembled and extended arithmetically.
    function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [9:0] addr, input logic [31:0] wd,
                                  output logic err, output logic [31:0] rd);
        int n;
        longint v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || ((int'(addr) % n) != 0);
        rd  = '0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < n; i++) mb[int'(addr) + i] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v += longint'(mb[int'(addr) + i]) << (8 * i);
            if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
            rd = v[31:0];
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && a_rv) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=resp_valid required=no_response");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check({e.tag, "_err"}, 32'(a_err), 32'(e.err));
                check({e.tag, "_rdata"}, a_rdata, e.rdata);
                check({e.tag, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [9:0] addr, input logic [31:0] wd, input bit track,
                         input bit fixed, input logic ferr, input logic [31:0] fdata,
                         input string tag);
        int   n;
        logic e_err;
        logic [31:0] e_rd;
        exp_t e;
        @(negedge clk);
        a_valid = 1'b1; a_we = we; a_size = size; a_uns = uns; a_addr = addr; a_wdata = wd;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!a_ready) begin
            checks++;
            failures++;
            $display("FAIL %s_accept actual=timeout required=req_ready", tag);
            a_valid = 1'b0;
            return;
        end
        if (track) begin
            model(we, size, uns, addr, wd, e_err, e_rd);
            e.err   = fixed ? ferr : e_err;
            e.rdata = fixed ? fdata : e_rd;
            e.due   = cyc + 1 + LAT;
            e.tag   = tag;
            sbq.push_back(e);
        end
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic dir(input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wd,
                       input logic ferr, input logic [31:0] fdata, input string tag);
        issue(we, size, uns, addr, wd, 1'b1, 1'b1, ferr, fdata, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_rdy;
        int   n;
        rst_n = 1'b0;
        a_valid = 1'b0; a_we = 1'b0; a_size = 2'd0; a_uns = 1'b0; a_addr = '0; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_size = 2'd0; b_uns = 1'b0; b_addr = '0; b_wdata = '0;
        repeat (2) @(negedge clk);
        // A handshake under reset must leave no trace.
        a_valid = 1'b1; a_we = 1'b1; a_size = 2'd2; a_addr = 10'h010; a_wdata = 32'h0BAD0BAD;
        @(negedge clk);
        check("rst_ready", 32'(a_ready), 32'd1);
        check("rst_resp_valid", 32'(a_rv), 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_err", 32'(a_err), 32'd0);
        check("rst_ready_lat0", 32'(b_ready), 32'd1);
        a_valid = 1'b0;
        rst_n = 1'b1;

        dir(1, 2'd2, 0, 10'h010, 32'hDEADBEEF, 0, 32'h0, "sw010");
        dir(0, 2'd2, 0, 10'h010, 32'h0, 0, 32'hDEADBEEF, "lw010");
        dir(1, 2'd2, 0, 10'h020, 32'h11223344, 0, 32'h0, "sw020");
        dir(1, 2'd0, 0, 10'h021, 32'h000000AA, 0, 32'h0, "sb021");
        dir(0, 2'd2, 0, 10'h020, 32'h0, 0, 32'h1122AA44, "lw020a");
        dir(1, 2'd1, 0, 10'h022, 32'h0000BEEF, 0, 32'h0, "sh022");
        dir(0, 2'd2, 0, 10'h020, 32'h0, 0, 32'hBEEFAA44, "lw020b");
        dir(1, 2'd2, 0, 10'h030, 32'h80FF7F01, 0, 32'h0, "sw030");
        dir(0, 2'd0, 0, 10'h030, 32'h0, 0, 32'h00000001, "lb030");
        dir(0, 2'd0, 0, 10'h033, 32'h0, 0, 32'hFFFFFF80, "lb033");
        dir(0, 2'd0, 1, 10'h033, 32'h0, 0, 32'h00000080, "lbu033");
        dir(0, 2'd1, 0, 10'h032, 32'h0, 0, 32'hFFFF80FF, "lh032");
        dir(0, 2'd1, 1, 10'h032, 32'h0, 0, 32'h000080FF, "lhu032");
        dir(0, 2'd2, 0, 10'h031, 32'h0, 1, 32'h0, "lw031_mis");
        dir(1, 2'd2, 0, 10'h040, 32'hCAFEF00D, 0, 32'h0, "sw040");
        dir(1, 2'd1, 0, 10'h041, 32'h00001234, 1, 32'h0, "sh041_mis");
        dir(0, 2'd2, 0, 10'h040, 32'h0, 0, 32'hCAFEF00D, "lw040");
        dir(0, 2'd3, 0, 10'h044, 32'h0, 1, 32'h0, "size3_ld");
        dir(1, 2'd3, 0, 10'h040, 32'h0, 1, 32'h0, "size3_st");
        dir(0, 2'd2, 0, 10'h040, 32'h0, 0, 32'hCAFEF00D, "lw040b");

        // Reset during WAIT drops the pending store and its response.
        dir(1, 2'd2, 0, 10'h050, 32'h5555AAAA, 0, 32'h0, "sw050");
        issue(1, 2'd2, 0, 10'h050, 32'h12345678, 1'b0, 1'b0, 0, 32'h0, "sw050_lost");
        rst_n = 1'b0;
        @(negedge clk);
        check("wait_rst_ready", 32'(a_ready), 32'd1);
        check("wait_rst_resp_valid", 32'(a_rv), 32'd0);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        dir(0, 2'd2, 0, 10'h050, 32'h0, 0, 32'h5555AAAA, "lw050");

        for (int w = 0; w < 64; w++)
            issue(1, 2'd2, 0, 10'(w * 4), $urandom, 1'b1, 1'b0, 0, 32'h0, "init");
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [1:0] sz;
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            issue(1'($urandom), sz, 1'($urandom), 10'($urandom_range(0, 255)), $urandom,
                  1'b1, 1'b0, 0, 32'h0, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Zero-latency instance with req_valid held high: accept every other cycle.
        @(negedge clk);
        b_valid = 1'b1; b_we = 1'b1; b_size = 2'd2; b_addr = 10'h008; b_wdata = 32'hCAFE0000;
        exp_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("lat0_ready", 32'(b_ready), 32'(exp_rdy));
            check("lat0_resp_valid", 32'(b_rv), 32'(!exp_rdy));
            if (b_rv) check("lat0_st_rdata", b_rdata, 32'h0);
            @(negedge clk);
            exp_rdy = !exp_rdy;
        end
        b_valid = 1'b0;
        @(negedge clk);
        b_valid = 1'b1; b_we = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        check("lat0_ld_valid", 32'(b_rv), 32'd1);
        check("lat0_ld_rdata", b_rdata, 32'hCAFE0000);
        check("lat0_ld_err", 32'(b_err), 32'd0);

        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual=%0d_pending required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
